// File: rtl/decode_stage.sv
// Registered RV32I decode stage: captures one instruction + PC per valid/ready
// transfer and presents split fields, format class and sign-extended immediate.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PC_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_instr,
  input  logic [PC_WIDTH-1:0]       in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [6:0]                op,
  output logic [2:0]                funct3,
  output logic [6:0]                funct7,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [XLEN-1:0]           imm,
  output logic [2:0]                fmt,
  output logic                      illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [PC_WIDTH-1:0]       pc;
    logic [6:0]                op;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]           imm;
    logic [2:0]                fmt;
    logic                      illegal;
  } dec_t;

  dec_t               dec_d, dec_q;
  logic               vld_q;
  logic               accept;
  logic signed [31:0] imm32;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    dec_d         = '0;
    dec_d.pc      = in_pc;
    dec_d.op      = in_instr[6:0];
    dec_d.funct3  = in_instr[14:12];
    dec_d.funct7  = in_instr[31:25];
    dec_d.rs1     = REG_ADDR_WIDTH'(in_instr[19:15]);
    dec_d.rs2     = REG_ADDR_WIDTH'(in_instr[24:20]);
    dec_d.rd      = REG_ADDR_WIDTH'(in_instr[11:7]);
    dec_d.fmt     = FMT_NONE;
    dec_d.illegal = 1'b0;
    imm32         = '0;
    case (in_instr[6:0])
      7'b0110011: dec_d.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_d.fmt = FMT_I;
        imm32     = 32'($signed(in_instr[31:20]));
      end
      7'b0100011: begin
        dec_d.fmt = FMT_S;
        imm32     = 32'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec_d.fmt = FMT_B;
        imm32     = 32'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_d.fmt = FMT_U;
        imm32     = $signed({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        dec_d.fmt = FMT_J;
        imm32     = 32'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      default: dec_d.illegal = 1'b1;
    endcase
    // every legal opcode above ends in 2'b11; keep the check explicit anyway
    if (in_instr[1:0] != 2'b11) begin
      dec_d.illegal = 1'b1;
      dec_d.fmt     = FMT_NONE;
      imm32         = '0;
    end
    dec_d.imm = XLEN'(imm32);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      dec_q       <= '0;
      dec_q.fmt   <= FMT_NONE;
    end else begin
      // flush kills both the held bundle and whatever is offered this cycle
      if (flush)          vld_q <= 1'b0;
      else if (accept)    vld_q <= 1'b1;
      else if (out_ready) vld_q <= 1'b0;
      if (accept) dec_q <= dec_d;
    end
  end

  assign out_valid = vld_q;
  assign out_pc    = dec_q.pc;
  assign op        = dec_q.op;
  assign funct3    = dec_q.funct3;
  assign funct7    = dec_q.funct7;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign rd        = dec_q.rd;
  assign imm       = dec_q.imm;
  assign fmt       = dec_q.fmt;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field/immediate decode per format,
// back-pressure, streaming, flush and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3, fmt;
  logic [4:0]  rs1, rs2, rd;

  int errs   = 0;
  int checks = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .op(op), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  logic [31:0] s_instr [4] = '{32'h00600193, 32'h00700213, 32'h00800293, 32'h00900313};
  logic [31:0] s_pc    [4] = '{32'h204, 32'h208, 32'h20C, 32'h210};
  logic [31:0] s_imm   [4] = '{32'd6, 32'd7, 32'd8, 32'd9};
  logic [31:0] s_rd    [4] = '{32'd3, 32'd4, 32'd5, 32'd6};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fmt",       32'(fmt),       32'd7);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_imm",       imm,            32'h0);
    chk("rst_pc",        out_pc,         32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // I-type: addi x1,x0,-1
    offer(32'hFFF00093, 32'h100); step();
    chk("i_valid", 32'(out_valid), 32'd1);
    chk("i_rd",    32'(rd),        32'd1);
    chk("i_rs1",   32'(rs1),       32'd0);
    chk("i_fmt",   32'(fmt),       32'd1);
    chk("i_imm",   imm,            32'hFFFFFFFF);
    chk("i_pc",    out_pc,         32'h100);
    chk("i_op",    32'(op),        32'h13);

    // S-type: sw x2,8(x1)
    offer(32'h0020A423, 32'h104); step();
    chk("s_fmt",    32'(fmt),    32'd2);
    chk("s_rs1",    32'(rs1),    32'd1);
    chk("s_rs2",    32'(rs2),    32'd2);
    chk("s_funct3", 32'(funct3), 32'd2);
    chk("s_imm",    imm,         32'h8);
    chk("s_pc",     out_pc,      32'h104);

    // B-type: beq -4
    offer(32'hFE000EE3, 32'h108); step();
    chk("b_fmt", 32'(fmt), 32'd3);
    chk("b_imm", imm,      32'hFFFFFFFC);

    // U-type: lui x5,0x12345
    offer(32'h123452B7, 32'h10C); step();
    chk("u_fmt", 32'(fmt), 32'd4);
    chk("u_rd",  32'(rd),  32'd5);
    chk("u_imm", imm,      32'h12345000);

    // J-type: jal x1,+2048
    offer(32'h001000EF, 32'h110); step();
    chk("j_fmt", 32'(fmt), 32'd5);
    chk("j_rd",  32'(rd),  32'd1);
    chk("j_imm", imm,      32'h800);

    // R-type: sub x10,x10,x11
    offer(32'h40B50533, 32'h114); step();
    chk("r_fmt",    32'(fmt),    32'd0);
    chk("r_funct7", 32'(funct7), 32'h20);
    chk("r_rs1",    32'(rs1),    32'd10);
    chk("r_rs2",    32'(rs2),    32'd11);
    chk("r_rd",     32'(rd),     32'd10);
    chk("r_imm",    imm,         32'h0);

    // illegal opcode and illegal low bits
    offer(32'h0000007F, 32'h118); step();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag",  32'(illegal),   32'd1);
    chk("ill_fmt",   32'(fmt),       32'd7);
    chk("ill_imm",   imm,            32'h0);
    offer(32'hFFF00091, 32'h11C); step();
    chk("ill_lo_flag", 32'(illegal), 32'd1);
    chk("ill_lo_imm",  imm,          32'h0);

    in_valid = 1'b0; step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // back-pressure: held bundle stays put for 3 cycles
    out_ready = 1'b0;
    offer(32'h00500113, 32'h200); step();
    chk("bp_load_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready",   32'(in_ready),  32'd0);
    offer(s_instr[0], s_pc[0]);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_pc",    out_pc,         32'h200);
      chk("bp_hold_imm",   imm,            32'd5);
    end

    // stream 4 back-to-back
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(s_instr[k], s_pc[k]); step();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_pc",    out_pc,         s_pc[k]);
      chk("st_imm",   imm,            s_imm[k]);
      chk("st_rd",    32'(rd),        s_rd[k]);
    end
    in_valid = 1'b0; step();
    chk("st_end_valid", 32'(out_valid), 32'd0);
    chk("st_end_pc",    out_pc,         32'h210);

    // flush overrides accept
    offer(32'hFFF00093, 32'h300); flush = 1'b1; step();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_pc",    out_pc,         32'h210);
    flush = 1'b0; in_valid = 1'b0; step();
    chk("fl_never_valid", 32'(out_valid), 32'd0);

    // flush kills a stalled bundle too
    offer(32'h00500113, 32'h400); step();
    chk("fl2_load_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0; flush = 1'b1; offer(32'h00600193, 32'h404); step();
    chk("fl2_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl2_after", 32'(out_valid), 32'd0);
    chk("fl2_pc",    out_pc,         32'h400);

    // asynchronous reset mid-cycle drops a held bundle
    out_ready = 1'b0;
    offer(32'h123452B7, 32'h500); step();
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_fmt",   32'(fmt),       32'd7);
    chk("ar_imm",   imm,            32'h0);
    chk("ar_pc",    out_pc,         32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("ar_in_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, handshaked successor to the combinational instruction-field decoder.
- Registers one fetched instruction plus PC per transfer.
- Extracts all fields and generates the fully sign-extended immediate for the R/I/S/B/U/J formats.
- Classifies the format, flags illegal encodings, and supports back-pressure and flush.
- Sits between fetch and register-read/control in the single-issue RV32I-style core.

Parameters:
- XLEN, 32, width of instruction, PC and immediate output.
- REG_ADDR_WIDTH, 5, register-address width of rs1/rs2/rd.
- PC_WIDTH, 32, width of the program counter carried alongside the instruction.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of the held instruction
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- in_instr  input  XLEN  raw instruction word
- in_pc  input  PC_WIDTH  PC of in_instr
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  downstream accepts bundle
- out_pc  output  PC_WIDTH  registered PC
- op  output  7  instr[6:0]
- funct3  output  3  instr[14:12]
- funct7  output  7  instr[31:25]
- rs1  output  REG_ADDR_WIDTH  instr[19:15]
- rs2  output  REG_ADDR_WIDTH  instr[24:20]
- rd  output  REG_ADDR_WIDTH  instr[11:7]
- imm  output  XLEN  sign-extended immediate per format
- fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none/illegal
- illegal  output  1  unsupported opcode or instr[1:0]!=2'b11

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, illegal=0, fmt=7.
  - All field, imm and out_pc registers are 0.
  - in_ready=1 once reset is released.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. The bundle is registered on that edge, giving exactly 1-cycle latency.
  - If out_valid && !out_ready, all outputs hold stable and no new input is accepted.
  - Simultaneous drain and fill (out_ready=1 with a new accept) gives back-to-back throughput of 1 per cycle.
  - No accept and out_ready=1 → out_valid falls to 0. Data registers may hold stale values.
- Flush:
  - out_valid←0 on the next edge.
  - The input presented in the same cycle is discarded, i.e. flush overrides accept.
  - in_ready remains the combinational expression above.
- Format decode on opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - anything else → fmt=7, illegal=1
- Immediates (all sign-extended from bit 31 to XLEN):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
  - R and illegal: imm=0.
- Illegal instructions still present valid fields and out_valid=1. The consumer traps.
- Reset asserted mid-transfer drops the held bundle immediately.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with out_valid=1 → out_valid=0 asynchronously, fmt=7; after release in_ready=1.
- I-type: instr 0xFFF00093 (addi x1,x0,-1), pc 0x100 → next cycle out_valid=1, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF, out_pc=0x100.
- S/B-type:
  - 0x0020A423 (sw x2,8(x1)) → fmt=2, rs1=1, rs2=2, funct3=2, imm=0x00000008.
  - 0xFE000EE3 (beq −4) → fmt=3, imm=0xFFFFFFFC.
- U/J-type:
  - 0x123452B7 (lui x5) → fmt=4, rd=5, imm=0x12345000.
  - 0x001000EF (jal x1,+2048) → fmt=5, imm=0x00000800.
- Back-pressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs unchanged. Then stream 4 instructions with out_ready=1 → one output per cycle, in order, none lost or duplicated.
- Illegal and flush:
  - 0x0000007F → illegal=1, fmt=7, imm=0.
  - Assert flush with in_valid=1 → out_valid=0 next cycle, and that input never appears.
